// File: rtl/msg_checker_if.sv
// Message RAM read-side bus between the checker and the RAM.
// The checker drives the address and its status; the RAM supplies data.
interface msg_checker_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_idx;

    modport master (
        input  start,
        input  rdata,
        output addr,
        output busy,
        output done,
        output pass,
        output fail_idx
    );

    modport slave (
        output start,
        output rdata,
        input  addr,
        input  busy,
        input  done,
        input  pass,
        input  fail_idx
    );
endinterface

// File: rtl/msg_checker.sv
// Scans the decrypted message RAM and flags whether every byte is
// a legal plaintext character, reporting the first bad index.
module msg_checker #(
    parameter int MSG_LEN     = 32,
    parameter int ADDR_W      = 8,
    parameter int ALLOW_SPACE = 1
) (
    input  logic          clk,
    input  logic          reset,
    msg_checker_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST =
        ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              chk_vld_q, chk_vld_d;
    logic [ADDR_W-1:0] chk_idx_q, chk_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fidx_q, fidx_d;
    logic              legal;

    function automatic logic is_legal(
        input logic [7:0] b
    );
        logic lc;
        logic sp;
        lc = (b >= 8'h61) && (b <= 8'h7A);
        sp = (ALLOW_SPACE != 0) && (b == 8'h20);
        return lc || sp;
    endfunction

    assign legal = is_legal(bus.rdata);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        chk_vld_d = chk_vld_q;
        chk_idx_d = chk_idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fidx_d    = fidx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = SCAN;
                    addr_d    = '0;
                    chk_vld_d = 1'b0;
                    chk_idx_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    fidx_d    = '0;
                end
            end
            SCAN: begin
                // RAM has one cycle of latency, so the check
                // stage trails the issued address by one edge.
                chk_vld_d = 1'b1;
                chk_idx_d = addr_q;
                if (addr_q != LAST) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (chk_vld_q && !legal) begin
                    state_d   = DONE;
                    chk_vld_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    fidx_d    = chk_idx_q;
                end else if (chk_vld_q &&
                             chk_idx_q == LAST) begin
                    state_d   = DONE;
                    chk_vld_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b1;
                    fidx_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            chk_vld_q <= 1'b0;
            chk_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            chk_vld_q <= chk_vld_d;
            chk_idx_q <= chk_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fidx_q    <= fidx_d;
        end
    end

    assign bus.addr     = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_idx = fidx_q;

endmodule

// File: doc/msg_checker.md
Name: msg_checker

Overview:
- Reader for the decrypted-message RAM that arcfour writes.
- After a start pulse, reads MSG_LEN bytes from the RAM through its synchronous read port and checks that each byte is a legal plaintext character.
- Reports pass/fail and the first failing index.
- Drives the read-side address of the message RAM; its result is used to accept or reject a candidate key.

Parameters:
MSG_LEN, 32, number of message bytes scanned, addresses 0..MSG_LEN-1; legal range 1..256
ADDR_W, 8, width of RAM address
ALLOW_SPACE, 1, when 1, byte 8'h20 is legal in addition to 8'h61..8'h7A

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a scan when not busy
addr  output  ADDR_W  message RAM read address
rdata  input  8  message RAM q; valid one cycle after addr is sampled by the RAM
busy  output  1  high while scanning
done  output  1  sticky completion flag
pass  output  1  valid with done; 1 = every byte legal
fail_idx  output  ADDR_W  valid with done and pass=0; index of first illegal byte, else 0

Behaviour:
- Reset: reset=0 at a rising edge forces state IDLE, addr=0, busy=0, done=0, pass=0, fail_idx=0, all internal counters 0. This applies in any state; a scan in progress is aborted with no result.
- Legal byte: 8'h61..8'h7A ('a'..'z'), or 8'h20 when ALLOW_SPACE=1. Everything else is illegal, including 8'h00 and uppercase.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge E0 -> SCAN.
  - Issue counter set to 0; addr=0 registered at E0.
  - busy=1 from E0; done=0, pass=0, fail_idx=0.
- SCAN, issue side:
  - Each cycle, addr = issue counter; the counter increments until it reaches MSG_LEN-1, then holds.
  - The address for byte k is present during the cycle after E(k).
- SCAN, check side:
  - A one-stage delay pipe (check_valid, check_idx) tracks the address issued two edges earlier.
  - Byte k is sampled from rdata at edge E(k+2).
- Fail path: the first illegal byte k at E(k+2) -> DONE, pass=0, fail_idx=k, busy=0, done=1. Remaining in-flight reads are discarded.
- Pass path: byte MSG_LEN-1 legal -> DONE at E(MSG_LEN+1), pass=1, fail_idx=0.
- Latency:
  - Full pass: done rises MSG_LEN+1 edges after the start-sampling edge (33 for MSG_LEN=32).
  - Fail at k: done rises k+2 edges after that edge.
- DONE:
  - done, pass and fail_idx are held; addr holds its last value.
  - start=1 -> clears done/pass/fail_idx and re-enters SCAN exactly as from IDLE, with the same timing.
- Start while busy (SCAN) is ignored; it has no effect on counters or results.
- Simultaneous reset=0 and start=1: reset wins.
- MSG_LEN=1:
  - addr stays 0.
  - done is at E2 relative to the start edge E0.
- MSG_LEN=256: the issue counter tops out at 8'hFF without wrapping to 0. The check index is ADDR_W bits; no wrap is permitted before termination.
- The block never writes the RAM and has no wren output.
- All outputs are registered.

Test Plan:
- RAM model with 1-cycle read latency preloaded with 32 bytes of "attack at dawn" plus space/lowercase padding; pulse start -> addr steps 0..31 on consecutive cycles, busy=1 for 33 cycles, done=1 exactly 33 edges after start, pass=1, fail_idx=0.
- Byte 5 = 8'h41 ('A'), rest legal -> done 7 edges after start, pass=0, fail_idx=5. Outputs are held for 20 further cycles with no start.
- Byte 0 = 8'h00 -> done 2 edges after start, pass=0, fail_idx=0. Byte 31 = 8'h7B -> done at edge 33, pass=0, fail_idx=31.
- ALLOW_SPACE=0 with byte 3 = 8'h20 -> pass=0, fail_idx=3. ALLOW_SPACE=1 with the same data -> pass=1.
- Extra start pulses at cycles 4 and 10 of a scan -> ignored; timing and result identical to a single-start run. Start in DONE after a fail with the data corrected -> done clears the next cycle, then a fresh pass result 33 edges later.
- reset=0 at cycle 12 of a scan -> next edge busy=0, done=0, pass=0, addr=0, fail_idx=0. Start asserted together with reset=0 -> stays IDLE.
